nes_debugger_spi_controller: RTL

//  SPI controller (initiator) that drives the NES debugger's SPI peripheral link: the host end of the debugger protocol.

---
 rtl/nes_debugger_pkg.sv | 45 ++++
 rtl/nes_debugger_spi_controller_if.sv | 32 +++
 rtl/nes_debugger_spi_controller_spi_clk_gen.sv | 52 +++++
 rtl/nes_debugger_spi_controller.sv | 139 +++++++++++++
 4 files changed

// File: rtl/nes_debugger_pkg.sv
// Definitions shared by the debugger SPI host controller and the debugger peripheral:
// controller state encodings, SPI mode, and the debugger command set.
package nes_debugger_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_XFER     = 3'd2,
    ST_GAP      = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_CS_IDLE  = 3'd5
  } state_e;

  // The link runs SPI mode 0, MSB first.
  localparam logic SPI_CPOL      = 1'b0;
  localparam logic SPI_CPHA      = 1'b0;
  localparam logic SPI_MSB_FIRST = 1'b1;
  localparam int   SPI_BYTE_BITS = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [7:0] {
    CMD_NOP       = 8'h00,
    CMD_ECHO      = 8'h01,
    CMD_CPU_HALT  = 8'h02,
    CMD_CPU_RUN   = 8'h03,
    CMD_CPU_STEP  = 8'h04,
    CMD_CPU_REGS  = 8'h05,
    CMD_CPU_MEM   = 8'h10,
    CMD_PPU_MEM   = 8'h11,
    CMD_CART_CFG  = 8'h20,
    CMD_QUERY_DBG = 8'h30
  } cmd_e;

  // Byte 0 of a frame: read/write flag in bit 7 above a 7-bit opcode.
  function automatic logic [7:0] cmd_header(input logic rw, input logic [6:0] opcode);
    return {rw, opcode};
  endfunction

  function automatic int byte_cycles(input int clks_per_half_bit);
    return 2 * SPI_BYTE_BITS * clks_per_half_bit;
  endfunction

endpackage

// File: rtl/nes_debugger_spi_controller_if.sv
// Client byte stream plus SPI pins of the debugger host controller, and its state for checkers.
interface nes_debugger_spi_controller_if;

  // Byte stream handshake: a byte moves on any clock edge where i_tx_dv and
  // o_tx_ready are both high; i_tx_last travels with it. i_tx_dv while
  // o_tx_ready is low is dropped. o_rx_dv is a one-cycle pulse, no back-pressure.
  logic        i_tx_dv;
  logic [7:0]  i_tx_byte;
  logic        i_tx_last;
  logic        o_tx_ready;
  logic        o_rx_dv;
  logic [7:0]  o_rx_byte;
  logic        o_busy;
  logic        o_spi_clk;
  logic        o_spi_copi;
  logic        i_spi_cipo;
  logic        o_spi_cs_n;
  nes_debugger_pkg::state_e o_dbg_state;

  modport master (
    output i_tx_dv, i_tx_byte, i_tx_last, i_spi_cipo,
    input  o_tx_ready, o_rx_dv, o_rx_byte, o_busy,
    input  o_spi_clk, o_spi_copi, o_spi_cs_n, o_dbg_state
  );

  modport slave (
    input  i_tx_dv, i_tx_byte, i_tx_last, i_spi_cipo,
    output o_tx_ready, o_rx_dv, o_rx_byte, o_busy,
    output o_spi_clk, o_spi_copi, o_spi_cs_n, o_dbg_state
  );

endinterface

// File: rtl/nes_debugger_spi_controller_spi_clk_gen.sv
// SCLK generator: half-bit counter producing SCLK (idle low) and one-cycle strobes
// that flag the clock edge on which SCLK rises or falls.
module spi_clk_gen #(
  parameter int CLKS_PER_HALF_BIT = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_sclk,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_HALF_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          half_done;

  assign half_done = i_en && (cnt_q == HALF_MAX);

  // Disabled means parked: counter zero and SCLK low, so every enable starts a fresh low half.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!i_en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (half_done) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign o_sclk = sclk_q;
  assign o_rise = half_done && !sclk_q;
  assign o_fall = half_done && sclk_q;

endmodule

// File: rtl/nes_debugger_spi_controller.sv
// SPI mode 0 host for the NES debugger link: frames client bytes into one CS_n window,
// shifting each byte out on COPI while capturing the reply from CIPO.
module nes_debugger_spi_controller
  import nes_debugger_pkg::*;
#(
  parameter int CLKS_PER_HALF_BIT = 8,
  parameter int CS_SETUP_CLKS     = 2,
  parameter int CS_HOLD_CLKS      = 2,
  parameter int CS_IDLE_CLKS      = 4
) (
  input logic i_clk,
  input logic i_reset,
  nes_debugger_spi_controller_if.slave bus
);

  localparam logic [15:0] SETUP_MAX = 16'(CS_SETUP_CLKS - 1);
  localparam logic [15:0] HOLD_MAX  = 16'(CS_HOLD_CLKS - 1);
  localparam logic [15:0] IDLE_MAX  = 16'(CS_IDLE_CLKS - 1);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_dv_q, rx_dv_d;
  logic        last_q, last_d;
  logic        cs_n_q, cs_n_d;

  logic        tx_ready;
  logic        accept;
  logic        sclk;
  logic        sclk_rise;
  logic        sclk_fall;

  spi_clk_gen #(
    .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
  ) u_spi_clk_gen (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (state_q == ST_XFER),
    .o_sclk  (sclk),
    .o_rise  (sclk_rise),
    .o_fall  (sclk_fall)
  );

  assign tx_ready = (state_q == ST_IDLE) || (state_q == ST_GAP);
  assign accept   = bus.i_tx_dv && tx_ready;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    last_d     = last_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d    = ST_CS_SETUP;
          tx_shift_d = bus.i_tx_byte;
          last_d     = bus.i_tx_last;
        end
      end
      ST_CS_SETUP: begin
        if (timer_q == SETUP_MAX) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (sclk_rise) rx_shift_d = {rx_shift_q[6:0], bus.i_spi_cipo};
        // Each falling edge advances COPI; the 8th one also closes the byte.
        if (sclk_fall) begin
          tx_shift_d = {tx_shift_q[6:0], 1'b0};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
            state_d   = last_q ? ST_CS_HOLD : ST_GAP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_GAP: begin
        if (accept) begin
          state_d    = ST_XFER;
          tx_shift_d = bus.i_tx_byte;
          last_d     = bus.i_tx_last;
        end
      end
      ST_CS_HOLD: begin
        if (timer_q == HOLD_MAX) state_d = ST_CS_IDLE;
      end
      ST_CS_IDLE: begin
        if (timer_q == IDLE_MAX) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    timer_d = (state_d != state_q) ? 16'd0 : timer_q + 16'd1;
    cs_n_d  = (state_d == ST_IDLE) || (state_d == ST_CS_IDLE);
  end

  // CS_n releases asynchronously on reset because the debugger's own reset hangs off it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= 16'd0;
      bit_idx_q  <= 3'd0;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
      last_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
      last_q     <= last_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign bus.o_tx_ready  = tx_ready;
  assign bus.o_rx_dv     = rx_dv_q;
  assign bus.o_rx_byte   = rx_byte_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_spi_clk   = sclk;
  assign bus.o_spi_copi  = tx_shift_q[7];
  assign bus.o_spi_cs_n  = cs_n_q;
  assign bus.o_dbg_state = state_q;

endmodule
